// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU pipeline: hazard FSM state encoding,
// jump-select constants and the default register-address width.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] JSEL_NONE      = 2'b00;
    localparam int         REG_AW_DEFAULT = 3;

    // Larger of two integers; used to size the shared stall/flush counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_sat_ctr.sv
// 16-bit event counter that saturates at all-ones and clears synchronously.
module hazard_sat_ctr (
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: hold at the ceiling instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / jump hazard controller with multi-cycle stall and flush sequencing.
// Optional macro HAZARD_CTRL_STATS_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [1:0]        ex_jsel,
    output logic              hazard_sw,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic              busy
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count
`endif
);

    localparam int CNT_MAX = max_int(STALL_CYCLES, FLUSH_CYCLES);
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lu_s;
    logic             jmp_s;

    // Hazard detection from the ID and EX stage fields; register 0 is ordinary.
    always_comb begin
        lu_s  = ex_mem_read & ex_reg_write &
                ((id_rs1_used & (id_rs1 == ex_rd)) |
                 (id_rs2_used & (id_rs2 == ex_rd)));
        jmp_s = (ex_jsel != JSEL_NONE);
    end

    // Mealy in S_RUN so a hazard acts in the cycle it is seen; the sequencing
    // states ignore detection, including on their final (cnt==1) cycle.
    always_comb begin
        hazard_sw     = 1'b0;
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        if (rst) begin
            hazard_sw     = 1'b1;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            ifid_flush    = 1'b1;
            state_d       = S_RUN;
            cnt_d         = CNT_ZERO;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (jmp_s) begin
                        hazard_sw  = 1'b1;
                        ifid_flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = S_FLUSH;
                            cnt_d   = FLUSH_LOAD;
                        end else begin
                            state_d = S_RUN;
                            cnt_d   = CNT_ZERO;
                        end
                    end else if (lu_s) begin
                        hazard_sw     = 1'b1;
                        pc_write_en   = 1'b0;
                        ifid_write_en = 1'b0;
                        if (STALL_CYCLES > 1) begin
                            state_d = S_STALL;
                            cnt_d   = STALL_LOAD;
                        end else begin
                            state_d = S_RUN;
                            cnt_d   = CNT_ZERO;
                        end
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_ZERO;
                    end
                end
                S_STALL: begin
                    hazard_sw     = 1'b1;
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_RUN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = S_STALL;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                S_FLUSH: begin
                    hazard_sw  = 1'b1;
                    ifid_flush = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_RUN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = S_FLUSH;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and counter registers, synchronously reset to an idle pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = ~rst & (state_q != S_RUN);

`ifdef HAZARD_CTRL_STATS_EN
    logic stall_inc_s;
    logic flush_inc_s;

    assign stall_inc_s = ~pc_write_en & ~rst;
    assign flush_inc_s = ifid_flush & ~rst;

    hazard_sat_ctr u_stall_ctr (
        .clk_i   (clk),
        .clr_i   (rst),
        .inc_i   (stall_inc_s),
        .count_o (stall_count)
    );

    hazard_sat_ctr u_flush_ctr (
        .clk_i   (clk),
        .clr_i   (rst),
        .inc_i   (flush_inc_s),
        .count_o (flush_count)
    );
`endif

endmodule
